// File: rtl/latency_aware_write_master.sv
// rtl/latency_aware_write_master.sv - Avalon-MM write master draining a show-ahead user FIFO into memory.
// Optional words_written counter is enabled by LATENCY_AWARE_WRITE_MASTER_WORD_COUNT_EN.
module latency_aware_write_master #(
    parameter int DATAWIDTH       = 32,
    parameter int BYTEENABLEWIDTH = 4,
    parameter int ADDRESSWIDTH    = 32,
    parameter int FIFODEPTH       = 32,
    parameter int FIFODEPTH_LOG2  = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       control_fixed_location,
    input  logic [ADDRESSWIDTH-1:0]    control_write_base,
    input  logic [ADDRESSWIDTH-1:0]    control_write_length,
    input  logic                       control_go,
    output logic                       control_done,
    output logic                       overflow,
    input  logic                       user_write_buffer,
    input  logic [DATAWIDTH-1:0]       user_buffer_data,
    output logic                       user_buffer_full,
    output logic [ADDRESSWIDTH-1:0]    master_address,
    output logic                       master_write,
    output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
    output logic [DATAWIDTH-1:0]       master_writedata,
    input  logic                       master_waitrequest
`ifdef LATENCY_AWARE_WRITE_MASTER_WORD_COUNT_EN
    ,
    output logic [ADDRESSWIDTH-1:0]    words_written
`endif
);

    localparam int CNT_W = FIFODEPTH_LOG2 + 1;
    localparam logic [ADDRESSWIDTH-1:0] WORD_BYTES = ADDRESSWIDTH'(BYTEENABLEWIDTH);
    localparam logic [ADDRESSWIDTH-1:0] LOW_MASK   = ADDRESSWIDTH'(BYTEENABLEWIDTH - 1);

    logic [ADDRESSWIDTH-1:0]   r_address;
    logic [ADDRESSWIDTH-1:0]   r_length;
    logic                      r_fixed_d1;
    logic                      r_overflow;
    logic [DATAWIDTH-1:0]      r_mem [FIFODEPTH];
    logic [FIFODEPTH_LOG2-1:0] r_wr_ptr;
    logic [FIFODEPTH_LOG2-1:0] r_rd_ptr;
    logic [CNT_W-1:0]          r_count;

    logic w_fifo_empty;
    logic w_fifo_full;
    logic w_accept;
    logic w_push_ok;

    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == CNT_W'(FIFODEPTH));
    assign w_accept     = master_write & ~master_waitrequest;
    // A full FIFO still takes a push when the head is leaving in the same cycle.
    assign w_push_ok    = user_write_buffer & (~w_fifo_full | w_accept);

    assign master_write      = (r_length != '0) & ~w_fifo_empty;
    assign master_address    = r_address;
    assign master_writedata  = r_mem[r_rd_ptr];
    assign master_byteenable = '1;
    assign control_done      = (r_length == '0);
    assign overflow          = r_overflow;
    assign user_buffer_full  = w_fifo_full;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= user_buffer_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_address  <= '0;
            r_length   <= '0;
            r_fixed_d1 <= 1'b0;
            r_overflow <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (control_go) begin
                r_address  <= control_write_base & ~LOW_MASK;
                r_length   <= control_write_length & ~LOW_MASK;
                r_fixed_d1 <= control_fixed_location;
                r_overflow <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_length <= r_length - WORD_BYTES;
                    if (!r_fixed_d1) begin
                        r_address <= r_address + WORD_BYTES;
                    end
                end
                if (user_write_buffer && !w_push_ok) begin
                    r_overflow <= 1'b1;
                end
            end
            // The slave has taken the head word on accept, so it leaves the FIFO even across a go.
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + FIFODEPTH_LOG2'(1);
            end
            if (w_accept) begin
                r_rd_ptr <= r_rd_ptr + FIFODEPTH_LOG2'(1);
            end
            if (w_push_ok && !w_accept) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_accept && !w_push_ok) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

`ifdef LATENCY_AWARE_WRITE_MASTER_WORD_COUNT_EN
    logic [ADDRESSWIDTH-1:0] r_words_written;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_words_written <= '0;
        end else if (control_go) begin
            r_words_written <= '0;
        end else if (w_accept) begin
            r_words_written <= r_words_written + ADDRESSWIDTH'(1);
        end
    end

    assign words_written = r_words_written;
`endif

endmodule

// File: tb/tb_latency_aware_write_master.sv
// tb/tb_latency_aware_write_master.sv - scoreboard bench for latency_aware_write_master.
module tb_latency_aware_write_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        control_fixed_location = 1'b0;
    logic [31:0] control_write_base = '0;
    logic [31:0] control_write_length = '0;
    logic        control_go = 1'b0;
    logic        control_done;
    logic        overflow;
    logic        user_write_buffer = 1'b0;
    logic [31:0] user_buffer_data = '0;
    logic        user_buffer_full;
    logic [31:0] master_address;
    logic        master_write;
    logic [3:0]  master_byteenable;
    logic [31:0] master_writedata;
    logic        master_waitrequest = 1'b0;
`ifdef LATENCY_AWARE_WRITE_MASTER_WORD_COUNT_EN
    logic [31:0] words_written;
`endif

    latency_aware_write_master dut (
        .clk                    (clk),
        .reset                  (reset),
        .control_fixed_location (control_fixed_location),
        .control_write_base     (control_write_base),
        .control_write_length   (control_write_length),
        .control_go             (control_go),
        .control_done           (control_done),
        .overflow               (overflow),
        .user_write_buffer      (user_write_buffer),
        .user_buffer_data       (user_buffer_data),
        .user_buffer_full       (user_buffer_full),
        .master_address         (master_address),
        .master_write           (master_write),
        .master_byteenable      (master_byteenable),
        .master_writedata       (master_writedata),
        .master_waitrequest     (master_waitrequest)
`ifdef LATENCY_AWARE_WRITE_MASTER_WORD_COUNT_EN
        ,
        .words_written          (words_written)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_pops = 0;
    logic [63:0] sb_q [$];
    logic [63:0] sb_exp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every accepted write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && master_write && !master_waitrequest) begin
            if (sb_q.size() == 0) begin
                check("unexpected_write", 64'(master_address), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                sb_exp = sb_q.pop_front();
                check("wr_addr", 64'(master_address), 64'(sb_exp[63:32]));
                check("wr_data", 64'(master_writedata), 64'(sb_exp[31:0]));
                n_pops++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        user_write_buffer = 1'b1;
        user_buffer_data  = d;
        tick();
        user_write_buffer = 1'b0;
    endtask

    task automatic start(input logic [31:0] base, input logic [31:0] len, input logic fixed);
        control_write_base     = base;
        control_write_length   = len;
        control_fixed_location = fixed;
        control_go             = 1'b1;
        tick();
        control_go = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int i;
        i = 0;
        while (!control_done && i < budget) begin
            tick();
            i++;
        end
        check(tag, 64'(control_done), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        repeat (2) tick();
        check("rst_done", 64'(control_done), 64'd1);
        check("rst_write", 64'(master_write), 64'd0);
        check("rst_full", 64'(user_buffer_full), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("byteenable", 64'(master_byteenable), 64'hF);
        reset = 1'b0;
        tick();

        // Basic write
        for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
        check("len0_no_write", 64'(master_write), 64'd0);
        for (int i = 0; i < 4; i++) sb_q.push_back({32'h1000 + 32'(4 * i), 32'hA0 + 32'(i)});
        start(32'h1000, 32'd16, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("basic_consec", 64'(master_write), 64'd1);
            tick();
        end
        check("basic_done_next", 64'(control_done), 64'd1);

        // Waitrequest and fixed location
        push(32'hB0);
        push(32'hB1);
        sb_q.push_back({32'h2000, 32'hB0});
        sb_q.push_back({32'h2000, 32'hB1});
        master_waitrequest = 1'b1;
        start(32'h2003, 32'd8, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("stall_write", 64'(master_write), 64'd1);
            check("stall_addr", 64'(master_address), 64'h2000);
            check("stall_data", 64'(master_writedata), 64'hB0);
            tick();
        end
        master_waitrequest = 1'b0;
        wait_done(10, "fixed_done");

        // Starved FIFO
        start(32'h3000, 32'd12, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("starved_write", 64'(master_write), 64'd0);
            check("starved_done", 64'(control_done), 64'd0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back({32'h3000 + 32'(4 * i), 32'hC0 + 32'(i)});
            push(32'hC0 + 32'(i));
            check("fallthrough_write", 64'(master_write), 64'd1);
            check("fallthrough_data", 64'(master_writedata), 64'(32'hC0 + 32'(i)));
            tick();
            check("starved_idle", 64'(master_write), 64'd0);
            if (i < 2) begin
                tick();
                tick();
            end
        end
        check("starved_done_end", 64'(control_done), 64'd1);

        // Full FIFO and overflow
        for (int i = 0; i < 32; i++) begin
            if (i == 31) check("not_full_31", 64'(user_buffer_full), 64'd0);
            push(32'hD00 + 32'(i));
        end
        check("full_32", 64'(user_buffer_full), 64'd1);
        check("no_ovf_32", 64'(overflow), 64'd0);
        push(32'hDEAD);
        check("ovf_33", 64'(overflow), 64'd1);
        check("full_33", 64'(user_buffer_full), 64'd1);
        for (int i = 0; i < 32; i++) sb_q.push_back({32'h4000 + 32'(4 * i), 32'hD00 + 32'(i)});
        start(32'h4000, 32'd128, 1'b0);
        check("go_clears_ovf", 64'(overflow), 64'd0);
        push(32'hE0);
        check("push_accept_full", 64'(user_buffer_full), 64'd1);
        check("push_accept_ovf", 64'(overflow), 64'd0);
        wait_done(100, "full_done");
        check("full_sb_empty", 64'(sb_q.size()), 64'd0);

        // Reset mid-transfer
        for (int i = 0; i < 7; i++) push(32'hF0 + 32'(i));
        sb_q.push_back({32'h5000, 32'hE0});
        for (int i = 0; i < 7; i++) sb_q.push_back({32'h5004 + 32'(4 * i), 32'hF0 + 32'(i)});
        p0 = n_pops;
        start(32'h5000, 32'd32, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("mid_pops", 64'(n_pops - p0), 64'd2);
        check("mid_rst_write", 64'(master_write), 64'd0);
        check("mid_rst_done", 64'(control_done), 64'd1);
        check("mid_rst_full", 64'(user_buffer_full), 64'd0);
        check("mid_rst_addr", 64'(master_address), 64'd0);
        tick();
        reset = 1'b0;
        sb_q.delete();
        start(32'h6000, 32'd4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("post_rst_no_write", 64'(master_write), 64'd0);
            tick();
        end
        check("post_rst_not_done", 64'(control_done), 64'd0);

        // Sub-word length rounds to zero
        start(32'h6000, 32'd3, 1'b0);
        check("short_len_done", 64'(control_done), 64'd1);

`ifdef LATENCY_AWARE_WRITE_MASTER_WORD_COUNT_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(32'h700 + 32'(i));
            sb_q.push_back({32'h7000 + 32'(4 * i), 32'h700 + 32'(i)});
        end
        start(32'h7000, 32'd20, 1'b0);
        wait_done(20, "wc_done1");
        check("wc_five", 64'(words_written), 64'd5);
        for (int i = 0; i < 3; i++) begin
            push(32'h800 + 32'(i));
            sb_q.push_back({32'h8000 + 32'(4 * i), 32'h800 + 32'(i)});
        end
        start(32'h8000, 32'd12, 1'b0);
        check("wc_cleared", 64'(words_written), 64'd0);
        wait_done(20, "wc_done2");
        check("wc_three", 64'(words_written), 64'd3);
`endif

        tick();
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
